// File: rtl/qeciphy_pkg.sv
// qeciphy_pkg: rx link sequencer state encoding, fault codes and backoff arithmetic.
package qeciphy_pkg;
  typedef enum logic [2:0] {
    ST_DRAIN     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_UP        = 3'd3,
    ST_BACKOFF   = 3'd4,
    ST_FATAL     = 3'd5
  } link_state_t;
  localparam logic [3:0] ERR_TIMEOUT  = 4'hF;
  localparam logic [3:0] ERR_RDY_LOST = 4'hE;
  // Doubling backoff, saturated to 16 bits and never shorter than the minimum off time.
  function automatic logic [15:0] backoff_len(input int base, input int min_off, input logic [2:0] retry);
    logic [47:0] raw;
    logic [15:0] sat;
    raw = 48'(base) << retry;
    sat = (raw > 48'hFFFF) ? 16'hFFFF : raw[15:0];
    return (32'(sat) < 32'(min_off)) ? 16'(min_off) : sat;
  endfunction
endpackage

// File: rtl/qeciphy_cycle_timer.sv
// qeciphy_cycle_timer: loadable down-counter; done_o while the count rests at zero.
module qeciphy_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done_o = cnt_q == '0;
  assign cnt_d = load_i ? val_i : done_o ? cnt_q : cnt_q - 1'b1;
  always_ff @(posedge clk_i) cnt_q <= cnt_d;
endmodule

// File: rtl/qeciphy_rx_link_sequencer.sv
// qeciphy_rx_link_sequencer: brings the rx controller up, retries with exponential backoff,
// and latches a fatal state once retries are exhausted.
module qeciphy_rx_link_sequencer
  import qeciphy_pkg::*;
#(
  parameter int MAX_RETRIES   = 3,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int MIN_OFF       = 16,
  parameter int BACKOFF_BASE  = 32,
  parameter int STABLE_CYCLES = 256
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       link_en_i,
  input  logic       rx_rdy_i,
  input  logic       rx_fault_fatal_i,
  input  logic [3:0] rx_error_code_i,
  output logic       rx_ctrl_enable_o,
  output logic       link_up_o,
  output logic       link_fatal_o,
  output logic [2:0] retry_cnt_o,
  output logic [3:0] last_err_o,
  output logic [2:0] state_o
);
  link_state_t state_q, state_d, tgt;
  logic [2:0] retry_q, retry_d;
  logic [3:0] err_q, err_d, code;
  logic en_q, en_d, up_q, up_d, fatal_q, fatal_d;
  logic fail, exhausted, tmr_load, tmr_done;
  logic [15:0] tmr_val, bo_len;
  assign exhausted = retry_q == 3'(MAX_RETRIES);
  assign bo_len = backoff_len(BACKOFF_BASE, MIN_OFF, retry_q);
  assign fail = (state_q == ST_WAIT_LOCK) ? (rx_fault_fatal_i || tmr_done) :
                (state_q == ST_UP) ? (rx_fault_fatal_i || !rx_rdy_i) : 1'b0;
  assign code = rx_fault_fatal_i ? rx_error_code_i :
                (state_q == ST_UP) ? ERR_RDY_LOST : ERR_TIMEOUT;
  // Every state change reloads the shared timer with the duration of the state being entered.
  assign tgt = rst_n_i ? state_d : ST_DRAIN;
  assign tmr_load = !rst_n_i || tgt != state_q;
  assign tmr_val = (tgt == ST_WAIT_LOCK) ? 16'(LOCK_TIMEOUT - 1) :
                   (tgt == ST_UP) ? 16'(STABLE_CYCLES - 1) :
                   (tgt == ST_BACKOFF) ? bo_len - 16'd1 : 16'(MIN_OFF - 1);
  qeciphy_cycle_timer #(.W(16)) u_timer (
    .clk_i  (clk_i),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_DRAIN;
      retry_q <= '0;
      err_q   <= '0;
      en_q    <= 1'b0;
      up_q    <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      en_q    <= en_d;
      up_q    <= up_d;
      fatal_q <= fatal_d;
    end
  end
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    err_d   = err_q;
    case (state_q)
      ST_DRAIN:     if (tmr_done) begin state_d = ST_IDLE; retry_d = '0; end
      ST_IDLE:      if (link_en_i) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (rx_rdy_i) state_d = ST_UP;
      ST_UP:        if (tmr_done) retry_d = '0;
      ST_BACKOFF:   if (tmr_done) state_d = ST_WAIT_LOCK;
      ST_FATAL:     if (!link_en_i) state_d = ST_DRAIN;
      default:      state_d = ST_DRAIN;
    endcase
    if (fail) begin
      err_d   = code;
      state_d = exhausted ? ST_FATAL : ST_BACKOFF;
      retry_d = exhausted ? retry_q : retry_q + 3'd1;
    end
    // Software disable beats faults, timeouts and lock in every active state.
    if (!link_en_i && state_q inside {ST_WAIT_LOCK, ST_UP, ST_BACKOFF}) begin
      state_d = ST_DRAIN;
      retry_d = retry_q;
      err_d   = err_q;
    end
  end
  always_comb begin
    en_d    = state_d inside {ST_WAIT_LOCK, ST_UP};
    up_d    = state_d == ST_UP;
    fatal_d = state_d == ST_FATAL;
  end
  assign rx_ctrl_enable_o = en_q;
  assign link_up_o        = up_q;
  assign link_fatal_o     = fatal_q;
  assign retry_cnt_o      = retry_q;
  assign last_err_o       = err_q;
  assign state_o          = state_q;
endmodule
